s27: RTL and testbench
======================

S27 -- requirements
Module: s27

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 CK  input  1  clock; all state updates on the rising edge.
REQ-003 RST  input  1  reset; one clock, asynchronous, active-high.
REQ-004 GND  input  1  ground tie; driven 0; no functional effect.
REQ-005 VDD  input  1  supply tie; driven 1; no functional effect.
REQ-006 G0  input  1  primary input 0.
REQ-007 G1  input  1  primary input 1.
REQ-008 G2  input  1  primary input 2.
REQ-009 G3  input  1  primary input 3.
REQ-010 G17  output  1  primary output; combinational (Mealy) from current state and inputs.

Function
REQ-011 The block SHALL implement the ISCAS-89 s27 benchmark with exactly three state flops: G5, G6, G7.
REQ-012 The block SHALL compute these internal nets exactly:
- G14 = NOT G0
- G8 = G14 AND G6
- G12 = NOR(G1, G7)
- G15 = G12 OR G8
- G16 = G3 OR G8
- G9 = NAND(G16, G15)
- G11 = NOR(G5, G9)
- G10 = NOR(G14, G11)
- G13 = NOR(G2, G12)
REQ-013 G17 SHALL equal NOT G11, with no register between the state and the output.
REQ-014 On each rising CK edge with RST low, the flops SHALL load G5<=G10, G6<=G11 and G7<=G13 simultaneously.
REQ-015 Input changes SHALL propagate to G17 within the same cycle, with zero cycles of latency.
REQ-016 The next-state value SHALL affect G17 one cycle after the edge that captures it.
REQ-017 There SHALL be no handshake and no enable: every edge out of reset updates all three flops.
REQ-018 All logic SHALL be single-bit boolean; no arithmetic.

Reset
REQ-019 While RST is high, G5, G6 and G7 SHALL be 0 immediately, without waiting for a clock edge, and SHALL hold 0.
REQ-020 Reset asserted mid-operation SHALL override any pending clock edge.
REQ-021 During reset, G17 SHALL follow the inputs with state 000; with all inputs 0, G17 = 1.
REQ-022 When RST falls, the first rising edge SHALL perform a normal state update.

Structure
REQ-023 A shared package s27_pkg SHALL hold the state-width constant (3) and the reset state value (3'b000).
REQ-024 One sub-module, s27_dff, SHALL be a single-bit D flop with asynchronous active-high reset to 0.
REQ-025 The top level SHALL instantiate s27_dff three times.
REQ-026 The top level SHALL hold the combinational gate network.
REQ-027 The block SHALL be synthesizable, contain no latches, and sit as one clock domain on CK.

Verification
REQ-028 Reset, inputs 0000 -> state 000, G17 = 1; after release and one edge with inputs 0000, state stays 000.
REQ-029 State 000, G0=1, G1=G2=G3=0 -> G17 = 1; next edge gives G5=1, G6=0, G7=0; then G17 = 1 for any inputs while G5=1.
REQ-030 State 000, G3=1, G0=G1=G2=0 -> G17 = 0 in the same cycle; next edge gives state G6=1 only (010).
REQ-031 State 010, all inputs 0 -> G17 = 0 and the state holds at 010 over repeated edges.
REQ-032 State 000, G1=1, G0=G2=G3=0 -> G17 = 1; next edge gives G7=1 only (001).
REQ-033 From state 010, assert RST between edges -> state 000 and G17 = 1 (inputs 0000) without a clock edge.
REQ-034 Random stimulus: compare against a golden copy of the block for at least 1000 runs of 8 cycles each (1 reset cycle plus 7 random-input cycles); G17 SHALL match every cycle.

Source files
------------

// File: rtl/s27_pkg.sv
// Shared constants for the s27 benchmark: state width and reset state.
package s27_pkg;
    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] RESET_STATE = 3'b000;
endpackage

// File: rtl/s27_dff.sv
// Single-bit D flop with asynchronous active-high reset to 0.
module s27_dff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end
endmodule

// File: rtl/s27.sv
// ISCAS-89 s27: three state flops (G5, G6, G7) and a Mealy gate network driving G17.
module s27
    import s27_pkg::*;
(
    input  logic CK,
    input  logic RST,
    input  logic GND,
    input  logic VDD,
    input  logic G0,
    input  logic G1,
    input  logic G2,
    input  logic G3,
    output logic G17
);
    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic g5, g6, g7;
    logic g8, g9, g10, g11, g12, g13, g14, g15, g16;
    logic unused_ties;

    // Supply ties carry no function.
    assign unused_ties = GND | ~VDD;

    assign g5 = state[2];
    assign g6 = state[1];
    assign g7 = state[0];

    assign g14 = ~G0;
    assign g8  = g14 & g6;
    assign g12 = ~(G1 | g7);
    assign g15 = g12 | g8;
    assign g16 = G3 | g8;
    assign g9  = ~(g16 & g15);
    assign g11 = ~(g5 | g9);
    assign g10 = ~(g14 | g11);
    assign g13 = ~(G2 | g12);

    assign G17 = ~g11;

    assign state_next = {g10, g11, g13};

    generate
        for (genvar gi = 0; gi < STATE_W; gi++) begin : g_state
            s27_dff u_dff (
                .clk(CK),
                .rst(RST),
                .d  (state_next[gi]),
                .q  (state[gi])
            );
        end
    endgenerate
endmodule

// File: tb/tb_s27.sv
// Directed and random checks of s27 against hand-derived values and a golden model.
`timescale 1ns/1ps
module tb_s27;
    import s27_pkg::*;

    logic CK = 1'b0;
    logic RST, GND, VDD, G0, G1, G2, G3;
    logic G17;
    int checks = 0;
    int errors = 0;

    always #5 CK = ~CK;

    s27 dut (
        .CK (CK),
        .RST(RST),
        .GND(GND),
        .VDD(VDD),
        .G0 (G0),
        .G1 (G1),
        .G2 (G2),
        .G3 (G3),
        .G17(G17)
    );

    wire [2:0] st = {dut.g5, dut.g6, dut.g7};

    // Returns {g17, next G5, next G6, next G7}; v = {G3,G2,G1,G0}.
    function automatic logic [3:0] golden(input logic [2:0] s, input logic [3:0] v);
        logic a, b, c, n8, n11, n12;
        a = s[2]; b = s[1]; c = s[0];
        n8  = ~v[0] & b;
        n12 = ~v[1] & ~c;
        n11 = ~a & (v[3] | n8) & (n12 | n8);
        return {~n11, v[0] & ~n11, n11, ~v[2] & ~n12};
    endfunction

    task automatic apply(input logic [3:0] v);
        {G3, G2, G1, G0} = v;
    endtask

    task automatic do_reset();
        @(posedge CK); #1;
        RST = 1'b1;
        apply(4'b0000);
        #2;
        RST = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (st !== RESET_STATE) begin errors++; $display("FAIL reset_async_state got %b want %b", st, RESET_STATE); end
        checks++; if (G17 !== 1'b1) begin errors++; $display("FAIL reset_g17 got %b want 1", G17); end
        @(posedge CK); #1;
        checks++; if (st !== 3'b000) begin errors++; $display("FAIL reset_hold_state got %b want 000", st); end
        RST = 1'b0;
        @(posedge CK); #1;
        checks++; if (st !== 3'b000) begin errors++; $display("FAIL reset_release_state got %b want 000", st); end
        checks++; if (G17 !== 1'b1) begin errors++; $display("FAIL reset_release_g17 got %b want 1", G17); end
        $display("reset: state %b G17 %b", st, G17);
    endtask

    task automatic test_g0_path();
        do_reset();
        apply(4'b0001);
        #1;
        checks++; if (G17 !== 1'b1) begin errors++; $display("FAIL g0_g17 got %b want 1", G17); end
        @(posedge CK); #1;
        checks++; if (st !== 3'b100) begin errors++; $display("FAIL g0_next got %b want 100", st); end
        for (int v = 0; v < 16; v++) begin
            apply(4'(v));
            #0.2;
            checks++; if (G17 !== 1'b1) begin errors++; $display("FAIL g5_g17 in %b got %b want 1", 4'(v), G17); end
        end
        $display("g0 path: state %b G17 %b", st, G17);
    endtask

    task automatic test_g3_path();
        do_reset();
        apply(4'b1000);
        #1;
        checks++; if (G17 !== 1'b0) begin errors++; $display("FAIL g3_g17 got %b want 0", G17); end
        @(posedge CK); #1;
        checks++; if (st !== 3'b010) begin errors++; $display("FAIL g3_next got %b want 010", st); end
        $display("g3 path: state %b G17 %b", st, G17);
    endtask

    task automatic test_hold_010();
        apply(4'b0000);
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++; if (G17 !== 1'b0) begin errors++; $display("FAIL hold_g17 cyc %0d got %b want 0", i, G17); end
            @(posedge CK); #1;
            checks++; if (st !== 3'b010) begin errors++; $display("FAIL hold_state cyc %0d got %b want 010", i, st); end
        end
        $display("hold 010: state %b G17 %b", st, G17);
    endtask

    task automatic test_async_reset();
        #2;
        RST = 1'b1;
        #0.5;
        checks++; if (st !== 3'b000) begin errors++; $display("FAIL async_rst_state got %b want 000", st); end
        checks++; if (G17 !== 1'b1) begin errors++; $display("FAIL async_rst_g17 got %b want 1", G17); end
        @(posedge CK); #1;
        RST = 1'b0;
        apply(4'b0001);
        @(posedge CK); #1;
        checks++; if (st !== 3'b100) begin errors++; $display("FAIL post_rst_edge got %b want 100", st); end
        $display("async reset: state %b G17 %b", st, G17);
    endtask

    task automatic test_g1_path();
        do_reset();
        apply(4'b0010);
        #1;
        checks++; if (G17 !== 1'b1) begin errors++; $display("FAIL g1_g17 got %b want 1", G17); end
        @(posedge CK); #1;
        checks++; if (st !== 3'b001) begin errors++; $display("FAIL g1_next got %b want 001", st); end
        $display("g1 path: state %b G17 %b", st, G17);
    endtask

    task automatic test_random();
        logic [2:0] ms;
        logic [3:0] v, g;
        int run_err;
        for (int r = 0; r < 1000; r++) begin
            run_err = 0;
            @(posedge CK); #1;
            RST = 1'b1;
            v = 4'($urandom);
            apply(v);
            ms = 3'b000;
            #3;
            g = golden(ms, v);
            checks++; if (G17 !== g[3]) begin errors++; run_err++; $display("FAIL rand_g17 run %0d cyc 0 got %b want %b", r, G17, g[3]); end
            for (int c = 1; c < 8; c++) begin
                @(posedge CK);
                ms = (c == 1) ? 3'b000 : g[2:0];
                #1;
                RST = 1'b0;
                v = 4'($urandom);
                apply(v);
                #3;
                g = golden(ms, v);
                checks++; if (G17 !== g[3]) begin errors++; run_err++; $display("FAIL rand_g17 run %0d cyc %0d got %b want %b", r, c, G17, g[3]); end
            end
            $display("random run %0d: last state %b errors %0d", r, ms, run_err);
        end
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        GND = 1'b0;
        VDD = 1'b1;
        apply(4'b0000);
        test_reset();
        test_g0_path();
        test_g3_path();
        test_hold_010();
        test_async_reset();
        test_g1_path();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
